// File: rtl/filter_storage_pkg.sv
// rtl/filter_storage_pkg.sv - shared sizes and types for the filter coefficient/sample store
package filter_storage_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/filter_storage_if.sv
// rtl/filter_storage_if.sv - write/read pointer port bundle between filter control and storage
// Signals: wren/wrptr/wrdata (write port), rden/rdptr (read port), rddata (registered read data).
// master: filter control side; slave: storage side.
interface filter_storage_if;
    import filter_storage_pkg::*;

    logic  wren;
    addr_t wrptr;
    word_t wrdata;
    logic  rden;
    addr_t rdptr;
    word_t rddata;

    modport master (
        output wren, wrptr, wrdata, rden, rdptr,
        input  rddata
    );

    modport slave (
        input  wren, wrptr, wrdata, rden, rdptr,
        output rddata
    );
endinterface

// File: rtl/filter_storage_ram.sv
// rtl/filter_storage_ram.sv - bare 1W1R array, synchronous write, read addressed directly
// Ports: clk, we/wa/wd (write), ra (read address), rd (array word at ra, before this edge's write).
// The read register lives in the top so it can carry reset, enable and bypass.
module filter_storage_ram
    import filter_storage_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t wa,
    input  word_t wd,
    input  addr_t ra,
    output word_t rd
);
    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];
endmodule

// File: rtl/filter_storage.sv
// rtl/filter_storage.sv - filter coefficient/sample store, 1024x32, one write and one read port
// Ports: clk, rst_n (async active-low, clears rddata only), bus (filter_storage_if.slave).
// Option: FILTER_STORAGE_BYPASS_EN makes a same-address read+write return the new wrdata.
module filter_storage
    import filter_storage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    filter_storage_if.slave    bus
);
    word_t ram_rd;
    word_t rddata_q;
    word_t rd_next;
    logic  ram_we;

    // Writes are dropped while reset is held, including one landing on the asserting edge.
    assign ram_we = bus.wren & rst_n;

    filter_storage_ram u_ram (
        .clk (clk),
        .we  (ram_we),
        .wa  (bus.wrptr),
        .wd  (bus.wrdata),
        .ra  (bus.rdptr),
        .rd  (ram_rd)
    );

`ifdef FILTER_STORAGE_BYPASS_EN
    always_comb begin
        rd_next = ram_rd;
        if (bus.wren && (bus.wrptr == bus.rdptr)) begin
            rd_next = bus.wrdata;
        end
    end
`else
    // ram_rd reflects contents before this edge's write: read-before-write.
    assign rd_next = ram_rd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rddata_q <= '0;
        end else if (bus.rden) begin
            rddata_q <= rd_next;
        end
    end

    assign bus.rddata = rddata_q;
endmodule

// File: tb/tb_filter_storage.sv
// tb/tb_filter_storage.sv - vector table plus scoreboard bench for filter_storage
module tb_filter_storage;
    import filter_storage_pkg::*;

`ifdef FILTER_STORAGE_BYPASS_EN
    localparam word_t COLL_EXP = 32'h22;
`else
    localparam word_t COLL_EXP = 32'h11;
`endif

    typedef struct {
        bit    wren;
        addr_t wrptr;
        word_t wrdata;
        bit    rden;
        addr_t rdptr;
        word_t exp;
        bit    chk;
    } vec_t;

    logic clk;
    logic rst_n;
    filter_storage_if bus ();

    filter_storage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[$];
    word_t sb[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: rddata=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit w, input addr_t wp, input word_t wd,
                       input bit r, input addr_t rp, input word_t e, input bit c);
        vec_t v;
        v.wren = w; v.wrptr = wp; v.wrdata = wd;
        v.rden = r; v.rdptr = rp; v.exp = e; v.chk = c;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.wren = 1'b0; bus.wrptr = '0; bus.wrdata = '0;
        bus.rden = 1'b0; bus.rdptr = '0;
    endtask

    initial begin
        word_t got;
        rst_n = 1'b0;
        drive_idle();

        // Sequential writes 1..5 with three idle cycles each; rddata must stay 0.
        for (int i = 1; i <= 5; i++) begin
            add(1'b1, addr_t'(i), word_t'(i), 1'b0, '0, 32'h0, 1'b1);
            for (int k = 0; k < 3; k++) add(1'b0, '0, '0, 1'b0, '0, 32'h0, 1'b1);
        end
        // Reads holding each address two cycles; hold check after address 3.
        for (int i = 1; i <= 5; i++) begin
            add(1'b0, '0, '0, 1'b1, addr_t'(i), word_t'(i), 1'b1);
            add(1'b0, '0, '0, 1'b1, addr_t'(i), word_t'(i), 1'b1);
            if (i == 3) begin
                add(1'b0, '0, '0, 1'b0, addr_t'(5), 32'd3, 1'b1);
                add(1'b0, '0, '0, 1'b0, addr_t'(5), 32'd3, 1'b1);
            end
        end
        // Boundary addresses.
        add(1'b1, addr_t'(0),    32'hDEADBEEF, 1'b0, '0, 32'h0, 1'b0);
        add(1'b1, addr_t'(1023), 32'hCAFEF00D, 1'b0, '0, 32'h0, 1'b0);
        add(1'b0, '0, '0, 1'b1, addr_t'(0),    32'hDEADBEEF, 1'b1);
        add(1'b0, '0, '0, 1'b1, addr_t'(1023), 32'hCAFEF00D, 1'b1);
        add(1'b0, '0, '0, 1'b1, addr_t'(1),    32'd1, 1'b1);
        // Same-address collision.
        add(1'b1, addr_t'(7), 32'h11, 1'b0, '0, 32'h0, 1'b0);
        add(1'b1, addr_t'(7), 32'h22, 1'b1, addr_t'(7), COLL_EXP, 1'b1);
        add(1'b0, '0, '0, 1'b1, addr_t'(7), 32'h22, 1'b1);
        // Simultaneous read/write to different addresses, then read the new word.
        add(1'b1, addr_t'(10), 32'hAA, 1'b1, addr_t'(5), 32'd5, 1'b1);
        add(1'b0, '0, '0, 1'b1, addr_t'(10), 32'hAA, 1'b1);
        // Back-to-back write then read.
        add(1'b1, addr_t'(9), 32'h99, 1'b0, '0, 32'h0, 1'b0);
        add(1'b0, '0, '0, 1'b1, addr_t'(9), 32'h99, 1'b1);
        // Leave rddata at 5 for the reset test.
        add(1'b0, '0, '0, 1'b1, addr_t'(5), 32'd5, 1'b1);

        #50;
        check("reset_during", bus.rddata, 32'h0);
        #50;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", bus.rddata, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wren = vecs[i].wren; bus.wrptr = vecs[i].wrptr; bus.wrdata = vecs[i].wrdata;
            bus.rden = vecs[i].rden; bus.rdptr = vecs[i].rdptr;
            if (vecs[i].chk) sb.push_back(vecs[i].exp);
            @(posedge clk); #1;
            if (vecs[i].chk) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: vector=%0d", i);
                end else begin
                    got = sb.pop_front();
                    check($sformatf("vec%0d", i), bus.rddata, got);
                end
            end
        end

        // Asynchronous reset between edges clears rddata at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.rddata, 32'h0);
        // A write attempted under reset must not land.
        @(negedge clk);
        bus.wren = 1'b1; bus.wrptr = addr_t'(5); bus.wrdata = 32'hBAD;
        bus.rden = 1'b1; bus.rdptr = addr_t'(5);
        @(posedge clk); #1;
        check("reset_hold", bus.rddata, 32'h0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", bus.rddata, 32'h0);
        @(negedge clk);
        bus.rden = 1'b1; bus.rdptr = addr_t'(5);
        sb.push_back(32'd5);
        @(posedge clk); #1;
        got = sb.pop_front();
        check("retained_after_reset", bus.rddata, got);
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        check("final_hold", bus.rddata, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/filter_storage.md
Name: filter_storage

Overview:
- Single-clock, dual-port (one write, one read) storage array holding filter coefficients/samples for the filter datapath.
- 1024 words x 32 bits by default.
- Synchronous write port and registered synchronous read port; the filter control logic addresses it with independent write and read pointers.

Parameters:
- DATA_W, 32, width of each stored word and of wrdata/rddata.
- ADDR_W, 10, pointer width.
- DEPTH, 1024, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- wren  input  1  write enable, sampled on rising clk.
- wrptr  input  ADDR_W  write address.
- wrdata  input  DATA_W  write data.
- rden  input  1  read enable, sampled on rising clk.
- rdptr  input  ADDR_W  read address.
- rddata  output  DATA_W  registered read data.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst_n low asynchronously forces rddata to 0; it stays 0 until the first enabled read after rst_n deasserts.
  - The array contents are not reset. Contents of never-written words are undefined (X in simulation), and verification must not depend on them.
- Write:
  - On a rising clk with wren=1, mem[wrptr] <= wrdata.
  - wren=0: no change.
  - Writes are ignored while rst_n is low.
- Read:
  - On a rising clk with rden=1, rddata <= mem[rdptr]. Latency is exactly 1 cycle from address sample to rddata valid.
  - rden=0: rddata holds its previous value.
  - Reads are ignored while rst_n is low.
- Addressing: the full ADDR_W range 0..DEPTH-1 is valid. There is no wrap logic and no out-of-range condition.
- Simultaneous read and write, different addresses: both take effect in the same cycle.
- Simultaneous read and write, same address: by default rddata returns the OLD contents (read-before-write). See Optional Feature.
- Back-to-back operations: a write in cycle N is visible to a read sampled in cycle N+1.
- Reset mid-operation: an in-flight write on the same edge as the rst_n assertion is discarded, and rddata goes to 0 immediately.

Optional Feature:
- Macro: FILTER_STORAGE_BYPASS_EN.
- Defined: on a same-cycle read and write to the same address with rden=1 and wren=1, rddata <= wrdata (write-through bypass). The memory is still written.
- Undefined: read-before-write; rddata gets the prior mem contents.
- Latency is 1 cycle in both builds.

Decomposition:
- Package filter_storage_pkg holds:
  - localparams DATA_W=32, ADDR_W=10, DEPTH=1024;
  - typedefs addr_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]).
- Sub-module filter_storage_ram:
  - Contains the bare array with synchronous write and unregistered-address synchronous read; inferable as block RAM.
  - The top level adds reset of rddata, enable gating and the optional bypass mux.

Test Plan:
- Reset: hold rst_n=0 for 100 ns with clk period 10 ns, then release -> rddata=0, and rddata stays 0 while rden=0.
- Sequential writes: write 1,2,3,4,5 to addresses 1..5 (wren pulsed one cycle each, 3 idle cycles between), then rden=1 with rdptr stepping 1..5, holding each address 2 cycles -> rddata = 1,2,3,4,5, each valid 1 cycle after its rdptr is sampled.
- Hold: after reading address 3 (value 3), deassert rden and change rdptr to 5 -> rddata stays 3.
- Boundaries: write 0xDEADBEEF to address 0 and 0xCAFEF00D to address 1023; read both -> exact values returned, and address 1 is unaffected.
- Same-address collision: mem[7]=0x11; in one cycle set wren=1, wrdata=0x22, wrptr=7, rden=1, rdptr=7.
  - Without FILTER_STORAGE_BYPASS_EN -> rddata=0x11.
  - With FILTER_STORAGE_BYPASS_EN -> rddata=0x22.
  - In both builds, the next read of address 7 returns 0x22.
- Async reset mid-read: with rddata=5, assert rst_n low between clock edges -> rddata=0 immediately. Release rst_n and read address 5 -> rddata=5 (contents retained).
